// File: rtl/core_buf_exchange.sv
// Snapshots each core's published word pair and releases a barrier once all enabled cores have published.
// Latency: a capture is visible to reads the next cycle; the barrier releases on the edge that completes the set; reads are combinational.
// Backpressure: none; cores hold buf_flag until all_buf_flags is seen, and flags raised during release wait for the next collect.
module core_buf_exchange #(
    parameter int NCORES  = 8,
    parameter int EPOCH_W = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NCORES-1:0]      core_enable,
    input  logic [32*NCORES-1:0]   buf_val_1,
    input  logic [32*NCORES-1:0]   buf_val_2,
    input  logic [NCORES-1:0]      buf_flag,
    input  logic [3*NCORES-1:0]    buf_val_1_addr,
    input  logic [3*NCORES-1:0]    buf_val_2_addr,
    output logic [32*NCORES-1:0]   buf_val_1_select,
    output logic [32*NCORES-1:0]   buf_val_2_select,
    output logic                   all_buf_flags,
    output logic [EPOCH_W-1:0]     epoch
);

    typedef enum logic {COLLECT, RELEASE} state_t;

    state_t            state;
    logic [NCORES-1:0] pending;
    logic [NCORES-1:0] capture;
    logic              barrier_done;
    logic [31:0]       snap_1 [NCORES];
    logic [31:0]       snap_2 [NCORES];

    // Disabled cores count as arrived; an all-disabled system never releases.
    always_comb begin
        capture      = (state == COLLECT) ? (core_enable & buf_flag & ~pending) : '0;
        barrier_done = (&(pending | capture | ~core_enable)) && (|core_enable);
    end

    // Addresses with no matching core fall through to zero.
    always_comb begin
        buf_val_1_select = '0;
        buf_val_2_select = '0;
        for (int i = 0; i < NCORES; i++) begin
            for (int j = 0; j < NCORES; j++) begin
                if (buf_val_1_addr[3*i +: 3] == 3'(j))
                    buf_val_1_select[32*i +: 32] = snap_1[j];
                if (buf_val_2_addr[3*i +: 3] == 3'(j))
                    buf_val_2_select[32*i +: 32] = snap_2[j];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= COLLECT;
            pending       <= '0;
            all_buf_flags <= 1'b0;
            epoch         <= '0;
            for (int i = 0; i < NCORES; i++) begin
                snap_1[i] <= '0;
                snap_2[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    for (int i = 0; i < NCORES; i++) begin
                        if (capture[i]) begin
                            snap_1[i] <= buf_val_1[32*i +: 32];
                            snap_2[i] <= buf_val_2[32*i +: 32];
                        end
                    end
                    pending <= pending | capture;
                    if (barrier_done) begin
                        state         <= RELEASE;
                        all_buf_flags <= 1'b1;
                    end
                end
                RELEASE: begin
                    if ((buf_flag & core_enable) == '0) begin
                        state         <= COLLECT;
                        pending       <= '0;
                        all_buf_flags <= 1'b0;
                        epoch         <= epoch + EPOCH_W'(1);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_core_buf_exchange.sv
// Bench for core_buf_exchange: an 8-core and a 4-core instance driven by directed and random steps.
// A per-instance arrival/snapshot model predicts selects, barrier output and epoch after every edge.
module tb_core_buf_exchange;

    logic Clk;
    logic Reset;

    // Per-instance stimulus (index 0: 8 cores, index 1: 4 cores)
    logic [7:0]  en   [2];
    logic [7:0]  flag [2];
    logic [31:0] v1   [2][8];
    logic [31:0] v2   [2][8];
    logic [2:0]  a1   [2][8];
    logic [2:0]  a2   [2][8];
    logic [31:0] sel1 [2][8];
    logic [31:0] sel2 [2][8];
    logic        abf  [2];
    logic [7:0]  ep   [2];

    logic [255:0] v1_8, v2_8, s1_8, s2_8;
    logic [23:0]  a1_8, a2_8;
    logic [127:0] v1_4, v2_4, s1_4, s2_4;
    logic [11:0]  a1_4, a2_4;

    // Reference model state
    bit          m_rel  [2];
    logic [7:0]  m_pend [2];
    logic [31:0] m_s1   [2][8];
    logic [31:0] m_s2   [2][8];
    int          m_ep   [2];

    int tests = 0;
    int fails = 0;

    for (genvar i = 0; i < 8; i++) begin : g_pack8
        assign v1_8[32*i +: 32] = v1[0][i];
        assign v2_8[32*i +: 32] = v2[0][i];
        assign a1_8[3*i +: 3]   = a1[0][i];
        assign a2_8[3*i +: 3]   = a2[0][i];
        assign sel1[0][i]       = s1_8[32*i +: 32];
        assign sel2[0][i]       = s2_8[32*i +: 32];
    end
    for (genvar i = 0; i < 4; i++) begin : g_pack4
        assign v1_4[32*i +: 32] = v1[1][i];
        assign v2_4[32*i +: 32] = v2[1][i];
        assign a1_4[3*i +: 3]   = a1[1][i];
        assign a2_4[3*i +: 3]   = a2[1][i];
        assign sel1[1][i]       = s1_4[32*i +: 32];
        assign sel2[1][i]       = s2_4[32*i +: 32];
    end
    for (genvar i = 4; i < 8; i++) begin : g_unused4
        assign sel1[1][i] = '0;
        assign sel2[1][i] = '0;
    end

    core_buf_exchange #(.NCORES(8), .EPOCH_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .core_enable(en[0]),
        .buf_val_1(v1_8), .buf_val_2(v2_8), .buf_flag(flag[0]),
        .buf_val_1_addr(a1_8), .buf_val_2_addr(a2_8),
        .buf_val_1_select(s1_8), .buf_val_2_select(s2_8),
        .all_buf_flags(abf[0]), .epoch(ep[0])
    );

    core_buf_exchange #(.NCORES(4), .EPOCH_W(8)) dut4 (
        .Clk(Clk), .Reset(Reset), .core_enable(en[1][3:0]),
        .buf_val_1(v1_4), .buf_val_2(v2_4), .buf_flag(flag[1][3:0]),
        .buf_val_1_addr(a1_4), .buf_val_2_addr(a2_4),
        .buf_val_1_select(s1_4), .buf_val_2_select(s2_4),
        .all_buf_flags(abf[1]), .epoch(ep[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int ncores(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_rel[d]  = 1'b0;
        m_pend[d] = '0;
        m_ep[d]   = 0;
        for (int i = 0; i < 8; i++) begin
            m_s1[d][i] = '0;
            m_s2[d][i] = '0;
        end
    endtask

    // One clock edge of barrier semantics, evaluated on the inputs held across that edge.
    task automatic model_edge(input int d);
        int  nc;
        bit  everyone_in;
        bit  any_enabled;
        bit  any_waiting;
        nc = ncores(d);
        if (Reset) begin
            model_reset(d);
        end else if (m_rel[d]) begin
            any_waiting = 1'b0;
            for (int i = 0; i < nc; i++)
                if (en[d][i] && flag[d][i]) any_waiting = 1'b1;
            if (!any_waiting) begin
                m_rel[d]  = 1'b0;
                m_pend[d] = '0;
                m_ep[d]   = (m_ep[d] + 1) % 256;
            end
        end else begin
            for (int i = 0; i < nc; i++) begin
                if (en[d][i] && flag[d][i] && !m_pend[d][i]) begin
                    m_s1[d][i]   = v1[d][i];
                    m_s2[d][i]   = v2[d][i];
                    m_pend[d][i] = 1'b1;
                end
            end
            everyone_in = 1'b1;
            any_enabled = 1'b0;
            for (int i = 0; i < nc; i++) begin
                if (en[d][i]) begin
                    any_enabled = 1'b1;
                    if (!m_pend[d][i]) everyone_in = 1'b0;
                end
            end
            if (everyone_in && any_enabled) m_rel[d] = 1'b1;
        end
    endtask

    task automatic check_all();
        int ad;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abf%0d", d), {31'b0, abf[d]}, {31'b0, m_rel[d]});
            chk($sformatf("epoch%0d", d), {24'b0, ep[d]}, m_ep[d]);
            for (int i = 0; i < ncores(d); i++) begin
                ad = a1[d][i];
                chk($sformatf("sel1_%0d_%0d", d, i), sel1[d][i], (ad < ncores(d)) ? m_s1[d][ad] : 32'h0);
                ad = a2[d][i];
                chk($sformatf("sel2_%0d_%0d", d, i), sel2[d][i], (ad < ncores(d)) ? m_s2[d][ad] : 32'h0);
            end
        end
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic rand_vals();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                v1[d][i] = $urandom;
                v2[d][i] = $urandom;
                a1[d][i] = 3'($urandom_range(0, 7));
                a2[d][i] = 3'($urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        en[0] = 8'hFF;  en[1] = 8'h0F;
        flag[0] = 8'h00; flag[1] = 8'h00;
        rand_vals();
        model_reset(0);
        model_reset(1);
        step();
        step();
        chk("reset_abf", {31'b0, abf[0]}, 32'h0);
        chk("reset_epoch", {24'b0, ep[0]}, 32'h0);
        chk("reset_read", sel1[0][0], 32'h0);
        Reset = 1'b0;
        step();

        // Staggered arrival, core i at cycle 2*i
        for (int i = 0; i < 8; i++) begin
            v1[0][i] = 32'h100 + i;
            v2[0][i] = 32'h200 + i;
        end
        a1[0][3] = 3'd5;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cyc % 2 == 0) flag[0][cyc/2] = 1'b1;
            step();
            if (cyc == 13) chk("t1_not_yet", {31'b0, abf[0]}, 32'h0);
        end
        chk("t1_release", {31'b0, abf[0]}, 32'h1);
        chk("t1_read", sel1[0][3], 32'h105);
        chk("t1_read2", sel2[0][7], (a2[0][7] < 8) ? 32'h200 + a2[0][7] : 32'h0);

        // Drop, then run enough barriers to wrap the epoch
        flag[0] = 8'h00;
        step();
        chk("t2_drop", {31'b0, abf[0]}, 32'h0);
        chk("t2_epoch", {24'b0, ep[0]}, 32'h1);
        for (int b = 0; b < 255; b++) begin
            rand_vals();
            flag[0] = 8'hFF; flag[1] = 8'h0F;
            step();
            flag[0] = 8'h00; flag[1] = 8'h00;
            step();
        end
        chk("t2_wrap", {24'b0, ep[0]}, 32'h0);

        // Core 7 disabled
        en[0] = 8'h7F;
        flag[0] = 8'h7F;
        step();
        chk("t3_release", {31'b0, abf[0]}, 32'h1);
        flag[0] = 8'h00;
        step();
        flag[0] = 8'h80;
        repeat (4) step();
        chk("t3_ignored", {31'b0, abf[0]}, 32'h0);
        flag[0] = 8'h00;
        en[0] = 8'hFF;
        step();

        // Input change while pending is not recaptured
        v1[0][2] = 32'hAAAA;
        a1[0][3] = 3'd2;
        flag[0] = 8'h04;
        step();
        v1[0][2] = 32'h5555;
        step();
        step();
        chk("t4_hold", sel1[0][3], 32'hAAAA);
        flag[0] = 8'hFF;
        step();
        flag[0] = 8'h00;
        step();

        // 4-core instance: out-of-range address and single-edge release
        a1[1][0] = 3'd6;
        step();
        chk("t5_oob", sel1[1][0], 32'h0);
        flag[1] = 8'h0F;
        step();
        chk("t5_single", {31'b0, abf[1]}, 32'h1);
        flag[1] = 8'h00;
        step();

        // Random traffic with occasional reset and enable changes
        repeat (1500) begin
            for (int d = 0; d < 2; d++) begin
                en[d] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
                if (d == 1) en[d] = en[d] & 8'h0F;
                if (m_rel[d]) begin
                    for (int i = 0; i < 8; i++) flag[d][i] = ($urandom_range(0, 5) == 0);
                end else begin
                    for (int i = 0; i < 8; i++)
                        if ($urandom_range(0, 3) == 0) flag[d][i] = 1'b1;
                end
            end
            rand_vals();
            Reset = ($urandom_range(0, 299) == 0);
            step();
        end
        Reset = 1'b0;

        // Reset while released
        en[0] = 8'hFF; en[1] = 8'h0F;
        flag[0] = 8'h00; flag[1] = 8'h00;
        step();
        step();
        flag[0] = 8'hFF; flag[1] = 8'h0F;
        step();
        chk("t6_released", {31'b0, abf[0]}, 32'h1);
        Reset = 1'b1;
        step();
        chk("t6_abf", {31'b0, abf[0]}, 32'h0);
        chk("t6_epoch", {24'b0, ep[0]}, 32'h0);
        chk("t6_read", sel1[0][0], 32'h0);
        Reset = 1'b0;
        flag[0] = 8'h00; flag[1] = 8'h00;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
